// File: rtl/stack_pointer_unit.sv
// stack_pointer_unit: NUM_STACKS independent hardware stack pointers with
// occupancy tracking, full/empty status and sticky overflow/underflow flags.
//
// Ports:
//   CLK       in   rising-edge clock
//   Reset     in   synchronous active-high reset
//   Push      in   [NUM_STACKS]        per-stack push request
//   Pop       in   [NUM_STACKS]        per-stack pop request
//   ErrClear  in   [NUM_STACKS]        per-stack clear of sticky error flags
//   SPOut     out  [NUM_STACKS*WIDTH]  next-free-slot address (push address)
//   TopAddr   out  [NUM_STACKS*WIDTH]  current top entry address (pop/peek)
//   Count     out  [NUM_STACKS*CW]     occupancy per stack
//   Empty     out  [NUM_STACKS]        Count == 0
//   Full      out  [NUM_STACKS]        Count == DEPTH
//   Overflow  out  [NUM_STACKS]        sticky: push while full
//   Underflow out  [NUM_STACKS]        sticky: pop while empty
module stack_pointer_unit #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned NUM_STACKS = 2,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned STEP       = 2,
   parameter logic [NUM_STACKS*WIDTH-1:0] STACK_BASE = {16'hFFFE, 16'h8000},
   parameter logic [NUM_STACKS-1:0]       GROW_DOWN  = 2'b10,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic                        CLK,
   input  logic                        Reset,
   input  logic [NUM_STACKS-1:0]       Push,
   input  logic [NUM_STACKS-1:0]       Pop,
   input  logic [NUM_STACKS-1:0]       ErrClear,
   output logic [NUM_STACKS*WIDTH-1:0] SPOut,
   output logic [NUM_STACKS*WIDTH-1:0] TopAddr,
   output logic [NUM_STACKS*CW-1:0]    Count,
   output logic [NUM_STACKS-1:0]       Empty,
   output logic [NUM_STACKS-1:0]       Full,
   output logic [NUM_STACKS-1:0]       Overflow,
   output logic [NUM_STACKS-1:0]       Underflow
);

   localparam longint unsigned ASPACE = 64'd1 << WIDTH;
   localparam longint unsigned SPAN   = 64'(STEP) * 64'(DEPTH);

   if (NUM_STACKS < 1 || DEPTH < 1) begin : g_bad_size
      $error("stack_pointer_unit: NUM_STACKS and DEPTH must be >= 1");
   end
   if (STEP == 0 || 64'(STEP) >= ASPACE) begin : g_bad_step
      $error("stack_pointer_unit: STEP must be nonzero and < 2^WIDTH");
   end
   if (SPAN > ASPACE) begin : g_bad_span
      $error("stack_pointer_unit: STEP*DEPTH exceeds the address space");
   end

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   for (genvar i = 0; i < NUM_STACKS; i++) begin : g_stack
      // Signed step expressed as a modulo-2^WIDTH addend.
      localparam logic [WIDTH-1:0] DIR =
         GROW_DOWN[i] ? (WIDTH'(0) - STEP_W) : STEP_W;
      localparam logic [WIDTH-1:0] BASE = STACK_BASE[i*WIDTH +: WIDTH];

      logic [WIDTH-1:0] sp_q, sp_d;
      logic [CW-1:0]    cnt_q, cnt_d;
      logic             ovf_q, ovf_d;
      logic             udf_q, udf_d;
      logic             empty_w, full_w;

      assign empty_w = (cnt_q == '0);
      assign full_w  = (cnt_q == CW'(DEPTH));

      always_comb begin
         sp_d  = sp_q;
         cnt_d = cnt_q;
         // A new error event in this cycle overrides the clear.
         ovf_d = ovf_q & ~ErrClear[i];
         udf_d = udf_q & ~ErrClear[i];
         unique case ({Push[i], Pop[i]})
            2'b10: begin
               if (full_w) begin
                  ovf_d = 1'b1;
               end else begin
                  sp_d  = sp_q + DIR;
                  cnt_d = cnt_q + CW'(1);
               end
            end
            2'b01: begin
               if (empty_w) begin
                  udf_d = 1'b1;
               end else begin
                  sp_d  = sp_q - DIR;
                  cnt_d = cnt_q - CW'(1);
               end
            end
            // 2'b11 replaces the top entry in place; 2'b00 holds.
            default: ;
         endcase
      end

      always_ff @(posedge CLK) begin
         if (Reset) begin
            sp_q  <= BASE;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
         end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
         end
      end

      assign SPOut[i*WIDTH +: WIDTH]   = sp_q;
      // Meaningless while empty; consumers gate on Empty.
      assign TopAddr[i*WIDTH +: WIDTH] = sp_q - DIR;
      assign Count[i*CW +: CW]         = cnt_q;
      assign Empty[i]                  = empty_w;
      assign Full[i]                   = full_w;
      assign Overflow[i]               = ovf_q;
      assign Underflow[i]              = udf_q;
   end

endmodule
